rst_release_seq: RTL
====================

# rst_release_seq

Reset release sequencer that sits directly downstream of the per-domain reset synchronizer. It takes the synchronized, active-high domain reset and releases a bank of subsystem resets one stage at a time, in order. Before releasing the next stage it waits for the current stage's done/lock indication, then waits a fixed settle gap. A stage that never reports done is caught by a timeout, which re-asserts every stage reset and flags the error.

## Interface

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs (>= 2).
- HOLD_CYCLES, 16: edges all resets stay asserted after rst/sw_rst_req (>= 1).
- GAP_CYCLES, 8: settle edges between a stage's done and the next stage's release (0 allowed).
- TIMEOUT_CYCLES, 255: max edges to wait for stage_done after a release (>= 1).
- SW, ceil(log2(NUM_STAGES)): err_stage width.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset (synchronized domain reset).
- sw_rst_req  input  1  one-cycle request to re-run the full sequence.
- stage_done  input  NUM_STAGES  per-stage done/lock; bit k is sampled only while waiting on stage k.
- stage_rst_out  output  NUM_STAGES  active-high reset per stage; bit 0 is released first.
- all_ready  output  1  high once every stage has been released and acknowledged.
- timeout_err  output  1  sticky; set when a stage times out.
- err_stage  output  SW  index of the stage that timed out.

## Operation

- All outputs are registered.
- Reset values: stage_rst_out all ones, all_ready 0, timeout_err 0, err_stage 0. State is ASSERT, counter is 0, stage index k is 0.
- States:
  - ASSERT: count HOLD_CYCLES edges, then clear stage_rst_out[0] and go to WAIT with k=0.
  - WAIT: sample stage_done[k] each edge.
    - If high and k < NUM_STAGES-1: go to GAP. If GAP_CYCLES=0, release stage k+1 on the same edge and stay in WAIT with k+1.
    - If high and k = NUM_STAGES-1: go to READY.
    - If TIMEOUT_CYCLES consecutive samples are low: go to ERROR.
  - GAP: count GAP_CYCLES edges. On the final one, clear stage_rst_out[k+1], increment k, and go to WAIT with the counter cleared.
  - READY: all_ready = 1. Hold until rst or sw_rst_req. stage_done is ignored here.
  - ERROR: stage_rst_out all ones, timeout_err = 1, err_stage = k, all_ready = 0. Hold until rst or sw_rst_req.
- Release order is strictly ascending. A released stage stays released until rst, sw_rst_req, or ERROR.
- Priority rules:
  - rst overrides everything.
  - sw_rst_req (when rst=0), in any state, goes to ASSERT on the next edge: stage_rst_out all ones, all_ready 0, timeout_err 0, err_stage 0, counter 0, k 0.
  - stage_done on the same edge as the timeout count is reached: done wins.
- stage_done bits for stages other than k are ignored.
- The counter is wide enough for max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) and never wraps. It clears on every state change.

## Timing

- Edge numbering: edge 1 is the first rising edge with rst=0 (or the first edge after the sw_rst_req edge).
- Stage 0 release: stage_rst_out[0] falls at edge HOLD_CYCLES.
- Stage k released at edge r:
  - stage_done[k] is first sampled at edge r+1.
  - If done is sampled high at edge t, stage k+1 is released at edge t+GAP_CYCLES.
  - If the last stage's done is sampled high at edge t, all_ready rises at edge t.
- Timeout: with no done sampled in edges r+1 through r+TIMEOUT_CYCLES, ERROR takes effect at edge r+TIMEOUT_CYCLES.
- sw_rst_req sampled at edge s: all resets assert at edge s, and stage 0 releases at edge s+HOLD_CYCLES.
- rst asserted mid-sequence: reset values appear at the next edge.

## Test plan

- Defaults, stage_done tied high, rst dropped:
  - stage_rst_out[0] falls at edge 16, [1] at 25, [2] at 34, [3] at 43.
  - all_ready rises at edge 44; timeout_err stays 0.
- stage_done[2] held low:
  - stage 2 releases at edge 34.
  - At edge 289: timeout_err=1, err_stage=2, stage_rst_out=4'b1111, all_ready=0.
  - Holds there for 100+ further edges.
- stage_done[2] pulsed high only at edge 289: no error; stage 3 releases at edge 297.
- In READY, pulse sw_rst_req at edge s:
  - Edge s: all resets assert and all_ready=0.
  - Stage 0 releases at edge s+16; the sequence completes again.
- sw_rst_req from ERROR clears timeout_err and err_stage.
- rst asserted mid-sequence:
  - rst high during GAP after stage 1: all reset values on the next edge.
  - rst and sw_rst_req high together: reset values, and no sequence starts until rst falls.
- Variant GAP_CYCLES=0, TIMEOUT_CYCLES=1, stage_done high:
  - Releases at edges 16, 17, 18, 19; all_ready at edge 20.
- Same variant with stage_done[0] low: ERROR at edge 17 with err_stage=0.

Source files
------------

// File: rtl/rst_release_seq.sv
// Reset release sequencer: releases a bank of stage resets in ascending order.
// Each release waits for the previous stage's done plus a settle gap; a silent stage trips a sticky timeout.
module rst_release_seq #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned SW             = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_rst_out,
  output logic                  all_ready,
  output logic                  timeout_err,
  output logic [SW-1:0]         err_stage
);

  localparam int unsigned CNT_MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_HG > TIMEOUT_CYCLES) ? CNT_MAX_HG : TIMEOUT_CYCLES;
  localparam int unsigned CW         = $clog2(CNT_MAX + 1);
  localparam int unsigned HOLD_LAST  = HOLD_CYCLES - 1;
  localparam int unsigned GAP_LAST   = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam int unsigned TO_LAST    = TIMEOUT_CYCLES - 1;
  localparam int unsigned LAST_STAGE = NUM_STAGES - 1;

  typedef enum logic [2:0] {
    S_ASSERT,
    S_WAIT,
    S_GAP,
    S_READY,
    S_ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] k;
  logic [SW-1:0] k_nxt;

  assign k_nxt = k + SW'(1);

  // Sequencer; rst and sw_rst_req both restart from ASSERT, rst taking precedence.
  always_ff @(posedge clk) begin
    if (rst || sw_rst_req) begin
      state         <= S_ASSERT;
      cnt           <= '0;
      k             <= '0;
      stage_rst_out <= '1;
      all_ready     <= 1'b0;
      timeout_err   <= 1'b0;
      err_stage     <= '0;
    end else begin
      case (state)
        S_ASSERT: begin
          if (cnt == CW'(HOLD_LAST)) begin
            stage_rst_out[0] <= 1'b0;
            k                <= '0;
            cnt              <= '0;
            state            <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Done is checked before the timeout so a late done on the final edge still counts.
        S_WAIT: begin
          if (stage_done[k]) begin
            cnt <= '0;
            if (k == SW'(LAST_STAGE)) begin
              all_ready <= 1'b1;
              state     <= S_READY;
            end else if (GAP_CYCLES == 0) begin
              stage_rst_out[k_nxt] <= 1'b0;
              k                    <= k_nxt;
            end else begin
              state <= S_GAP;
            end
          end else if (cnt == CW'(TO_LAST)) begin
            stage_rst_out <= '1;
            all_ready     <= 1'b0;
            timeout_err   <= 1'b1;
            err_stage     <= k;
            cnt           <= '0;
            state         <= S_ERROR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_GAP: begin
          if (cnt == CW'(GAP_LAST)) begin
            stage_rst_out[k_nxt] <= 1'b0;
            k                    <= k_nxt;
            cnt                  <= '0;
            state                <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
